// File: rtl/fifo_cdc_pkg.sv
// fifo_cdc_pkg: sizing and Gray-code helpers shared by the write- and read-side FIFO controllers
package fifo_cdc_pkg;

    // Gray helpers work on zero-extended values up to this width, so any pointer width up to it is served
    localparam int GRAY_MAX_W = 32;

    function automatic int clog2_safe(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2_safe(depth) + 1;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_synchronizer.sv
// gray_ptr_synchronizer: multi-stage flop chain bringing a Gray pointer into the local clock domain
module gray_ptr_synchronizer #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // shift the foreign pointer through the chain, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_write_controller.sv
// fifo_write_controller: write-domain pointer, memory strobe and full/level/overflow flags for the dual-clock FIFO
module fifo_write_controller
    import fifo_cdc_pkg::*;
#(
    parameter int NUM_ADDRESS        = 8,
    parameter int ALMOST_FULL_THRESH = NUM_ADDRESS - 2,
    parameter int SYNC_STAGES        = 2,
    localparam int ADDR_W            = clog2_safe(NUM_ADDRESS),
    localparam int PTR_W             = ptr_width(NUM_ADDRESS)
) (
    input  logic              w_clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [PTR_W-1:0]  read_ptr_gray,
    input  logic              clear_overflow,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [PTR_W-1:0]  write_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [PTR_W-1:0]  fill_level,
    output logic              overflow
);

    // Gray full pattern: the top two bits differ from the read pointer, also valid when ADDR_W is 1
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
    localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(ALMOST_FULL_THRESH);

    logic [PTR_W-1:0] wbin, wbin_next, wgray_next, rq_sync, rbin_sync, level_next;

    gray_ptr_synchronizer #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (w_clk),
        .rst_n (reset),
        .d     (read_ptr_gray),
        .q     (rq_sync)
    );

    assign push_ready    = !full;
    assign write_enable  = push_valid && !full;
    assign write_address = wbin[ADDR_W-1:0];
    assign wbin_next     = wbin + PTR_W'(write_enable);
    assign wgray_next    = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_next)));
    assign rbin_sync     = PTR_W'(gray2bin(GRAY_MAX_W'(rq_sync)));
    assign level_next    = wbin_next - rbin_sync;

    // flags look at the post-push pointer so a write is reflected at the same edge
    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            wbin           <= '0;
            write_ptr_gray <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            fill_level     <= '0;
            overflow       <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            write_ptr_gray <= wgray_next;
            full           <= wgray_next == (rq_sync ^ FULL_MASK);
            almost_full    <= level_next >= AF_THRESH;
            fill_level     <= level_next;
            overflow       <= (push_valid && full) || (overflow && !clear_overflow);
        end
    end

endmodule

// File: tb/tb_fifo_write_controller.sv
// tb_fifo_write_controller: scoreboard bench driving directed and random pushes/reads against a count-based model
module tb_fifo_write_controller;

    localparam int N  = 8;
    localparam int PW = 4;
    localparam int AW = 3;

    logic          w_clk = 1'b0;
    logic          reset = 1'b0;
    logic          push_valid = 1'b1;
    logic          clear_overflow = 1'b0;
    logic [PW-1:0] read_ptr_gray = '0;
    logic          push_ready, write_enable, full, almost_full, overflow;
    logic [AW-1:0] write_address;
    logic [PW-1:0] write_ptr_gray, fill_level;

    fifo_write_controller #(.NUM_ADDRESS(N), .ALMOST_FULL_THRESH(6), .SYNC_STAGES(2)) dut (
        .w_clk          (w_clk),
        .reset          (reset),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .read_ptr_gray  (read_ptr_gray),
        .clear_overflow (clear_overflow),
        .write_enable   (write_enable),
        .write_address  (write_address),
        .write_ptr_gray (write_ptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .fill_level     (fill_level),
        .overflow       (overflow)
    );

    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [PW-1:0] wgray;
        logic          full;
        logic          af;
        logic [PW-1:0] fill;
        logic          ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // model state: total writes and reads as plain counts, read count delayed through a queue
    int            wcount, rcount;
    int            rq[$];
    logic          m_full, m_af, m_ovf;
    logic [PW-1:0] m_fill, m_wgray;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] gray(input int p);
        int q;
        q = p % 16;
        return PW'(q ^ (q >> 1));
    endfunction

    task automatic model_reset();
        wcount = 0;
        rcount = 0;
        rq = {};
        rq.push_back(0);
        rq.push_back(0);
        m_full = 1'b0;
        m_af = 1'b0;
        m_ovf = 1'b0;
        m_fill = '0;
        m_wgray = '0;
    endtask

    task automatic step(input logic pv, input logic clr, input logic rinc);
        exp_t e;
        int   r_seen, lvl;
        logic acc;
        @(posedge w_clk);
        #2;
        if (rinc && rcount < wcount) rcount++;
        push_valid = pv;
        clear_overflow = clr;
        read_ptr_gray = gray(rcount);
        acc = pv && !m_full;
        e.we = acc;
        e.addr = AW'(wcount % N);
        e.wgray = m_wgray;
        e.full = m_full;
        e.af = m_af;
        e.fill = m_fill;
        e.ovf = m_ovf;
        exp_q.push_back(e);
        m_ovf = (pv && m_full) || (m_ovf && !clr);
        if (acc) wcount++;
        r_seen = rq.pop_front();
        rq.push_back(rcount);
        lvl = wcount - r_seen;
        m_fill = PW'(lvl);
        m_full = lvl == N;
        m_af = lvl >= 6;
        m_wgray = gray(wcount);
    endtask

    task automatic async_reset();
        @(negedge w_clk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_wptr_gray", write_ptr_gray, 0);
        chk("arst_full", full, 0);
        chk("arst_almost_full", almost_full, 0);
        chk("arst_fill_level", fill_level, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_write_address", write_address, 0);
        chk("arst_push_ready", push_ready, 1);
        chk("arst_write_enable", write_enable, push_valid);
        model_reset();
        push_valid = 1'b0;
        clear_overflow = 1'b0;
        read_ptr_gray = '0;
        #1;
        reset = 1'b1;
    endtask

    // monitor: compare every presented cycle against the oldest queued expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge w_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_enable", write_enable, e.we);
                chk("write_address", write_address, e.addr);
                chk("write_ptr_gray", write_ptr_gray, e.wgray);
                chk("full", full, e.full);
                chk("push_ready", push_ready, !e.full);
                chk("almost_full", almost_full, e.af);
                chk("fill_level", fill_level, e.fill);
                chk("overflow", overflow, e.ovf);
                if (full === 1'b1) chk("full_needs_level_8", fill_level, N);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        model_reset();
        @(negedge w_clk);
        @(negedge w_clk);
        #1;
        chk("rst_wptr_gray", write_ptr_gray, 0);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_fill_level", fill_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_write_address", write_address, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_write_enable", write_enable, 1);
        @(posedge w_clk);
        #2;
        push_valid = 1'b0;
        reset = 1'b1;
        repeat (8) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        async_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        push_valid = 1'b1;
        async_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        @(negedge w_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
